i2s_chunk_buffer: RTL and testbench

Multi-channel ping-pong capture buffer between the I2S receiver and the sample processor. It runs on a single clock and takes one frame strobe per LR period. Each channel's received word is truncated to sample width and written into the active bank. When a bank fills, the block announces a chunk to the processor and the writer swaps banks. An explicit release handshake returns banks to the writer, and overruns are detected and counted rather than silently overwriting data.

---
 rtl/i2s_chunk_buffer.sv | 166 ++++++++++++++++
 tb/tb_i2s_chunk_buffer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_chunk_buffer.sv
// Ping-pong capture buffer between the I2S receiver and the sample processor.
// The writer fills one bank while the processor reads the other. Completed
// banks are announced with chunk_ready and returned with chunk_release. Frames
// that arrive while both banks are full are dropped and counted.
module i2s_chunk_buffer #(
    parameter int unsigned WORD_SIZE   = 32,
    parameter int unsigned SAMPLE_SIZE = 24,
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned PTR_BITS    = 6,
    parameter int unsigned CH_BITS     = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_valid,
    input  logic [CHANNELS*WORD_SIZE-1:0] frame_data,
    output logic                          chunk_ready,
    output logic                          rd_bank,
    input  logic                          chunk_release,
    input  logic [CH_BITS-1:0]            rd_ch,
    input  logic [PTR_BITS-1:0]           rd_addr,
    output logic signed [SAMPLE_SIZE-1:0] rd_data,
    output logic [PTR_BITS-1:0]           wr_ptr,
    output logic                          active_bank,
    output logic                          stalled,
    output logic                          overrun,
    input  logic                          overrun_clr,
    output logic [15:0]                   drop_count
);

    localparam logic [PTR_BITS-1:0] LastPtr = PTR_BITS'(DEPTH - 1);

    typedef enum logic [0:0] {StFill, StStall} state_e;

    state_e                 state_q, state_d;
    logic [1:0]             full_q, full_d;
    logic [1:0]             full_rel;
    logic                   rd_bank_q, rd_bank_d;
    logic                   active_bank_q, active_bank_d;
    logic [PTR_BITS-1:0]    wr_ptr_q, wr_ptr_d;
    logic                   chunk_ready_q, chunk_ready_d;
    logic                   overrun_q, overrun_d;
    logic [15:0]            drop_count_q, drop_count_d;
    logic                   wr_en;
    logic [SAMPLE_SIZE-1:0] rd_data_q;

    // Sample storage: bank x channel x index, contents survive reset
    logic [SAMPLE_SIZE-1:0] mem [2][CHANNELS][DEPTH];

    // Release handling first, then writer FSM and overrun bookkeeping
    always_comb begin
        state_d       = state_q;
        rd_bank_d     = rd_bank_q;
        active_bank_d = active_bank_q;
        wr_ptr_d      = wr_ptr_q;
        chunk_ready_d = 1'b0;
        overrun_d     = overrun_q;
        drop_count_d  = drop_count_q;
        wr_en         = 1'b0;
        full_rel      = full_q;

        // rd_bank always names the oldest full bank, so checking it alone
        // also covers the "no bank full" case
        if (chunk_release && full_q[rd_bank_q]) begin
            full_rel[rd_bank_q] = 1'b0;
            rd_bank_d           = ~rd_bank_q;
        end
        full_d = full_rel;

        case (state_q)
            StFill: begin
                if (frame_valid) begin
                    wr_en = 1'b1;
                    if (wr_ptr_q == LastPtr) begin
                        wr_ptr_d              = '0;
                        full_d[active_bank_q] = 1'b1;
                        chunk_ready_d         = 1'b1;
                        // A release in this same cycle already freed the other bank
                        if (!full_rel[~active_bank_q]) begin
                            active_bank_d = ~active_bank_q;
                        end else begin
                            state_d = StStall;
                        end
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            StStall: begin
                // A frame arriving alongside the freeing release is still dropped
                if (frame_valid) begin
                    overrun_d = 1'b1;
                    if (drop_count_q != 16'hFFFF) begin
                        drop_count_d = drop_count_q + 16'd1;
                    end
                end
                if (!full_rel[~active_bank_q]) begin
                    active_bank_d = ~active_bank_q;
                    wr_ptr_d      = '0;
                    state_d       = StFill;
                end
            end
            default: state_d = StFill;
        endcase

        // Clear has priority over a simultaneous drop
        if (overrun_clr) begin
            overrun_d    = 1'b0;
            drop_count_d = 16'd0;
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StFill;
            full_q        <= 2'b00;
            rd_bank_q     <= 1'b0;
            active_bank_q <= 1'b0;
            wr_ptr_q      <= '0;
            chunk_ready_q <= 1'b0;
            overrun_q     <= 1'b0;
            drop_count_q  <= 16'd0;
        end else begin
            state_q       <= state_d;
            full_q        <= full_d;
            rd_bank_q     <= rd_bank_d;
            active_bank_q <= active_bank_d;
            wr_ptr_q      <= wr_ptr_d;
            chunk_ready_q <= chunk_ready_d;
            overrun_q     <= overrun_d;
            drop_count_q  <= drop_count_d;
        end
    end

    // Sample write: keep the top SAMPLE_SIZE bits of each channel word
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            for (int c = 0; c < CHANNELS; c++) begin
                mem[active_bank_q][c][wr_ptr_q] <=
                    frame_data[c*WORD_SIZE + WORD_SIZE-1 -: SAMPLE_SIZE];
            end
        end
    end

    // Registered read port; out-of-range selects return zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if ((32'(rd_ch) < CHANNELS) && (32'(rd_addr) < DEPTH)) begin
            rd_data_q <= mem[rd_bank_q][rd_ch][rd_addr];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign chunk_ready = chunk_ready_q;
    assign rd_bank     = rd_bank_q;
    assign rd_data     = rd_data_q;
    assign wr_ptr      = wr_ptr_q;
    assign active_bank = active_bank_q;
    assign stalled     = (state_q == StStall);
    assign overrun     = overrun_q;
    assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_i2s_chunk_buffer.sv
// Bench for i2s_chunk_buffer: directed scenarios plus randomized traffic,
// checked every cycle against a chunk-counting reference model.
module tb_i2s_chunk_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance: 2 channels, 64 samples per bank
    logic               rst_n;
    logic               frame_valid;
    logic [63:0]        frame_data;
    logic               chunk_ready;
    logic               rd_bank;
    logic               chunk_release;
    logic [0:0]         rd_ch;
    logic [5:0]         rd_addr;
    logic signed [23:0] rd_data;
    logic [5:0]         wr_ptr;
    logic               active_bank;
    logic               stalled;
    logic               overrun;
    logic               overrun_clr;
    logic [15:0]        drop_count;

    i2s_chunk_buffer u_dut (
        .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .frame_data(frame_data),
        .chunk_ready(chunk_ready), .rd_bank(rd_bank), .chunk_release(chunk_release),
        .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data), .wr_ptr(wr_ptr),
        .active_bank(active_bank), .stalled(stalled), .overrun(overrun),
        .overrun_clr(overrun_clr), .drop_count(drop_count)
    );

    // Variant instance: 4 channels, 16 samples per bank
    logic               v_rst_n = 1'b0;
    logic               v_frame_valid = 1'b0;
    logic [127:0]       v_frame_data = '0;
    logic               v_chunk_ready;
    logic               v_rd_bank;
    logic               v_chunk_release = 1'b0;
    logic [1:0]         v_rd_ch = '0;
    logic [3:0]         v_rd_addr = '0;
    logic signed [23:0] v_rd_data;
    logic [3:0]         v_wr_ptr;
    logic               v_active_bank;
    logic               v_stalled;
    logic               v_overrun;
    logic               v_overrun_clr = 1'b0;
    logic [15:0]        v_drop_count;

    i2s_chunk_buffer #(.CHANNELS(4), .DEPTH(16), .PTR_BITS(4), .CH_BITS(2)) u_dut4 (
        .clk(clk), .rst_n(v_rst_n), .frame_valid(v_frame_valid), .frame_data(v_frame_data),
        .chunk_ready(v_chunk_ready), .rd_bank(v_rd_bank), .chunk_release(v_chunk_release),
        .rd_ch(v_rd_ch), .rd_addr(v_rd_addr), .rd_data(v_rd_data), .wr_ptr(v_wr_ptr),
        .active_bank(v_active_bank), .stalled(v_stalled), .overrun(v_overrun),
        .overrun_clr(v_overrun_clr), .drop_count(v_drop_count)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: chunks completed/released counts define the bank state
    int          comp, rel, ptr, m_drops;
    bit          m_stall, m_ovr, m_ready;
    logic [23:0] mm [2][2][64];
    bit          mv [2][2][64];
    logic [23:0] exp_rd;
    bit          exp_rd_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic m_reset();
        comp = 0; rel = 0; ptr = 0; m_drops = 0;
        m_stall = 1'b0; m_ovr = 1'b0; m_ready = 1'b0;
        exp_rd = '0; exp_rd_v = 1'b1;
    endtask

    task automatic check_all();
        chk("chunk_ready", 32'(chunk_ready), 32'(m_ready));
        chk("rd_bank", 32'(rd_bank), 32'(rel % 2));
        chk("wr_ptr", 32'(wr_ptr), 32'(ptr));
        chk("active_bank", 32'(active_bank), m_stall ? 32'((comp - 1) % 2) : 32'(comp % 2));
        chk("stalled", 32'(stalled), 32'(m_stall));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("drop_count", 32'(drop_count), 32'(m_drops));
        if (exp_rd_v) chk("rd_data", {8'h0, rd_data}, {8'h0, exp_rd});
    endtask

    task automatic do_reset();
        rst_n = 1'b0; frame_valid = 1'b0; frame_data = '0; chunk_release = 1'b0;
        overrun_clr = 1'b0; rd_ch = '0; rd_addr = '0;
        @(posedge clk);
        m_reset();
        #1 check_all();
        rst_n = 1'b1;
    endtask

    // One clock of stimulus, model update, then compare
    task automatic step(input bit fv, input logic [63:0] d, input bit rl, input bit clr,
                        input int ch, input int ad);
        frame_valid = fv; frame_data = d; chunk_release = rl; overrun_clr = clr;
        rd_ch = 1'(ch); rd_addr = 6'(ad);
        @(posedge clk);
        exp_rd_v = mv[rel % 2][ch][ad];
        exp_rd   = mm[rel % 2][ch][ad];
        m_ready  = 1'b0;
        if (rl && comp > rel) rel++;
        if (!m_stall) begin
            if (fv) begin
                for (int c = 0; c < 2; c++) begin
                    mm[comp % 2][c][ptr] = d[c*32+8 +: 24];
                    mv[comp % 2][c][ptr] = 1'b1;
                end
                ptr++;
                if (ptr == 64) begin
                    ptr = 0; comp++; m_ready = 1'b1;
                    if (comp - rel == 2) m_stall = 1'b1;
                end
            end
        end else begin
            if (fv) begin
                m_ovr = 1'b1;
                if (m_drops < 65535) m_drops++;
            end
            if (comp - rel < 2) m_stall = 1'b0;
        end
        if (clr) begin m_ovr = 1'b0; m_drops = 0; end
        #1 check_all();
    endtask

    // Random traffic; release issued rel_dly cycles after each chunk_ready
    task automatic run(input int ncyc, input int fv_pct, input int rel_dly, input int clr_pct);
        int cd;
        bit fv, rl, cl;
        cd = -1;
        for (int i = 0; i < ncyc; i++) begin
            fv = ($urandom_range(99) < fv_pct);
            rl = (cd == 0);
            cl = ($urandom_range(99) < clr_pct);
            if (cd >= 0) cd--;
            step(fv, {$urandom, $urandom}, rl, cl, int'($urandom_range(1)),
                 int'($urandom_range(63)));
            if (m_ready && rel_dly >= 0) cd = rel_dly;
        end
    endtask

    initial begin
        logic [31:0]  lw, l5;
        logic [63:0]  d;
        logic [127:0] vd;
        logic [23:0]  vm [4][16];

        foreach (mv[b, c, a]) mv[b][c][a] = 1'b0;

        // Reset values, then 64 patterned frames forming one chunk
        do_reset();
        l5 = 32'h000100AB + 32'd5 * 32'h01000100;
        for (int i = 0; i < 64; i++) begin
            lw = 32'h000100AB + 32'(i) * 32'h01000100;
            step(1'b1, {~lw, lw}, 1'b0, 1'b0, 0, 5);
        end
        chk("t1_ready", 32'(chunk_ready), 32'd1);
        chk("t1_active", 32'(active_bank), 32'd1);
        chk("t1_rd_bank", 32'(rd_bank), 32'd0);
        step(1'b0, '0, 1'b0, 1'b0, 0, 5);
        chk("t1_rd_left", {8'h0, rd_data}, {8'h0, l5[31:8]});
        step(1'b0, '0, 1'b0, 1'b0, 1, 5);
        d = {~l5, l5};
        chk("t1_rd_right", {8'h0, rd_data}, {8'h0, d[63:40]});
        step(1'b0, '0, 1'b1, 1'b0, 0, 0);
        chk("t1_rel_rd_bank", 32'(rd_bank), 32'd1);

        // Continuous capture, release 10 cycles after each chunk
        do_reset();
        run(4 * 64 + 40, 100, 10, 0);
        chk("t2_overrun", 32'(overrun), 32'd0);

        // No release: two chunks then 72 drops, one release resumes in bank 0
        do_reset();
        for (int i = 0; i < 200; i++)
            step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, int'($urandom_range(1)),
                 int'($urandom_range(63)));
        chk("t3_drops", 32'(drop_count), 32'd72);
        chk("t3_stalled", 32'(stalled), 32'd1);
        chk("t3_overrun", 32'(overrun), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0, 0, 0);
        chk("t3_resume_stalled", 32'(stalled), 32'd0);
        chk("t3_resume_bank", 32'(active_bank), 32'd0);
        chk("t3_resume_ptr", 32'(wr_ptr), 32'd0);

        // Release coinciding with completion of frame 128
        do_reset();
        for (int i = 0; i < 127; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 0, i % 64);
        step(1'b1, {$urandom, $urandom}, 1'b1, 1'b0, 0, 0);
        chk("t4_stalled", 32'(stalled), 32'd0);
        chk("t4_active", 32'(active_bank), 32'd0);
        chk("t4_drops", 32'(drop_count), 32'd0);

        // Fill bank 0 to stall, then clear in the same cycle as a drop
        for (int i = 0; i < 64; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1, i);
        chk("t5_stalled", 32'(stalled), 32'd1);
        step(1'b1, {$urandom, $urandom}, 1'b0, 1'b1, 0, 0);
        chk("t5_clr_overrun", 32'(overrun), 32'd0);
        chk("t5_clr_drops", 32'(drop_count), 32'd0);
        step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 0, 0);
        chk("t5_next_overrun", 32'(overrun), 32'd1);
        chk("t5_next_drops", 32'(drop_count), 32'd1);

        // Reset mid-fill after 30 frames; first frame lands at bank 0 index 0
        do_reset();
        for (int i = 0; i < 30; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 0, 0);
        do_reset();
        d = {$urandom, $urandom};
        step(1'b1, d, 1'b0, 1'b0, 0, 0);
        chk("t6_ptr", 32'(wr_ptr), 32'd1);
        step(1'b0, '0, 1'b0, 1'b0, 0, 0);
        chk("t6_rd", {8'h0, rd_data}, {8'h0, d[31:8]});

        // Mixed random traffic with stalls, slow releases and occasional clears
        do_reset();
        run(900, 70, 100, 2);
        run(400, 50, 5, 1);

        // Variant: 4 channels, 16-deep banks
        @(posedge clk);
        #1;
        chk("v_reset_ready", 32'(v_chunk_ready), 32'd0);
        chk("v_reset_ptr", 32'(v_wr_ptr), 32'd0);
        chk("v_reset_active", 32'(v_active_bank), 32'd0);
        chk("v_reset_rd_bank", 32'(v_rd_bank), 32'd0);
        chk("v_reset_rd_data", {8'h0, v_rd_data}, 32'd0);
        chk("v_reset_stalled", 32'(v_stalled), 32'd0);
        chk("v_reset_ovr", 32'(v_overrun) | 32'(v_drop_count), 32'd0);
        v_rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            vd = {$urandom, $urandom, $urandom, $urandom};
            for (int c = 0; c < 4; c++) vm[c][i] = vd[c*32+8 +: 24];
            v_frame_valid = 1'b1; v_frame_data = vd;
            @(posedge clk);
            #1 chk("v_ready", 32'(v_chunk_ready), (i == 15) ? 32'd1 : 32'd0);
        end
        v_frame_valid = 1'b0;
        chk("v_active", 32'(v_active_bank), 32'd1);
        for (int a = 0; a < 16; a++) begin
            for (int c = 0; c < 4; c++) begin
                v_rd_ch = 2'(c); v_rd_addr = 4'(a);
                @(posedge clk);
                #1 chk("v_rd_data", {8'h0, v_rd_data}, {8'h0, vm[c][a]});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
